falafel_output_serializer: RTL and testbench

//  Response-side counterpart of the request parser. Buffers alloc/free responses from the

---
 rtl/falafel_output_serializer.sv | 194 +++++++++++++++++++
 tb/tb_falafel_output_serializer.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/falafel_output_serializer.sv
// Response serializer: buffers alloc/free responses per channel and
// emits each as a 2-word {header, data} packet with round-robin arbitration.
// Ports: clk_i, rst_i (sync, active-high); alloc_resp_* / free_resp_*
// val/rdy/data input channels; resp_val_o/resp_rdy_i/resp_data_o output
// stream; busy_o (FSM active or any buffer non-empty).

package falafel_pkg;
  localparam int DATA_W      = 64;
  localparam int MSG_ID_SIZE = 8;
  localparam int OPC_W       = 8;

  localparam logic [OPC_W-1:0] REQ_ALLOC_MEM = 8'h01;
  localparam logic [OPC_W-1:0] REQ_FREE_MEM  = 8'h02;

  typedef struct packed {
    logic [MSG_ID_SIZE-1:0] id;
    logic [DATA_W-1:0]      data;
  } alloc_entry_t;

  typedef struct packed {
    logic [DATA_W-OPC_W-MSG_ID_SIZE-1:0] rsvd;
    logic [OPC_W-1:0]                    opcode;
    logic [MSG_ID_SIZE-1:0]              id;
  } base_header_t;
endpackage

module falafel_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  // Extra pointer MSB distinguishes full from empty.
  assign full_o  = (r_wptr[AW] != r_rptr[AW]) &&
                   (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign empty_o = (r_wptr == r_rptr);
  assign data_o  = r_mem[r_rptr[AW-1:0]];
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && w_push) r_mem[r_wptr[AW-1:0]] <= data_i;
  end
endmodule

module falafel_output_serializer
  import falafel_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          alloc_resp_val_i,
  output logic                          alloc_resp_rdy_o,
  input  logic [MSG_ID_SIZE+DATA_W-1:0] alloc_resp_data_i,
  input  logic                          free_resp_val_i,
  output logic                          free_resp_rdy_o,
  input  logic [MSG_ID_SIZE+DATA_W-1:0] free_resp_data_i,
  output logic                          resp_val_o,
  input  logic                          resp_rdy_i,
  output logic [DATA_W-1:0]             resp_data_o,
  output logic                          busy_o
);
  typedef enum logic [1:0] {
    S_IDLE, S_HEADER, S_DATA
  } state_e;

  typedef enum logic {
    CH_ALLOC, CH_FREE
  } chan_e;

  state_e       r_state, w_state_d;
  chan_e        r_grant, w_grant_d;
  chan_e        r_prio,  w_prio_d;
  alloc_entry_t w_head_a, w_head_f, w_head;
  logic         w_full_a, w_full_f;
  logic         w_empty_a, w_empty_f;
  logic         w_pop_a, w_pop_f;
  base_header_t w_hdr;

  falafel_fifo #(
    .WIDTH (MSG_ID_SIZE + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_alloc_fifo (
    .clk_i   (clk_i),
    .rst_ni  (!rst_i),
    .push_i  (alloc_resp_val_i),
    .data_i  (alloc_resp_data_i),
    .pop_i   (w_pop_a),
    .data_o  (w_head_a),
    .full_o  (w_full_a),
    .empty_o (w_empty_a)
  );

  falafel_fifo #(
    .WIDTH (MSG_ID_SIZE + DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_free_fifo (
    .clk_i   (clk_i),
    .rst_ni  (!rst_i),
    .push_i  (free_resp_val_i),
    .data_i  (free_resp_data_i),
    .pop_i   (w_pop_f),
    .data_o  (w_head_f),
    .full_o  (w_full_f),
    .empty_o (w_empty_f)
  );

  assign alloc_resp_rdy_o = !w_full_a;
  assign free_resp_rdy_o  = !w_full_f;
  assign w_head  = (r_grant == CH_ALLOC) ? w_head_a : w_head_f;
  assign busy_o  = (r_state != S_IDLE) || !w_empty_a || !w_empty_f;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_grant <= CH_ALLOC;
      r_prio  <= CH_ALLOC;
    end else begin
      r_state <= w_state_d;
      r_grant <= w_grant_d;
      r_prio  <= w_prio_d;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_grant_d   = r_grant;
    w_prio_d    = r_prio;
    w_pop_a     = 1'b0;
    w_pop_f     = 1'b0;
    resp_val_o  = 1'b0;
    resp_data_o = '0;
    w_hdr        = '0;
    w_hdr.opcode = (r_grant == CH_ALLOC) ? REQ_ALLOC_MEM
                                         : REQ_FREE_MEM;
    w_hdr.id     = w_head.id;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty_a && !w_empty_f) begin
          w_grant_d = r_prio;
          w_state_d = S_HEADER;
        end else if (!w_empty_a) begin
          w_grant_d = CH_ALLOC;
          w_state_d = S_HEADER;
        end else if (!w_empty_f) begin
          w_grant_d = CH_FREE;
          w_state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        resp_val_o  = 1'b1;
        resp_data_o = w_hdr;
        if (resp_rdy_i) w_state_d = S_DATA;
      end
      S_DATA: begin
        resp_val_o  = 1'b1;
        resp_data_o = w_head.data;
        if (resp_rdy_i) begin
          w_pop_a   = (r_grant == CH_ALLOC);
          w_pop_f   = (r_grant == CH_FREE);
          w_prio_d  = (r_grant == CH_ALLOC) ? CH_FREE : CH_ALLOC;
          w_state_d = S_IDLE;
        end
      end
      default: w_state_d = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_falafel_output_serializer.sv
// Directed and randomized checks for falafel_output_serializer.
// Header layout: {48'b0, opcode[7:0], id[7:0]}; alloc op 0x01, free op 0x02.
module tb_falafel_output_serializer;
  logic        clk = 1'b0;
  logic        rst_i;
  logic        alloc_resp_val_i;
  logic        alloc_resp_rdy_o;
  logic [71:0] alloc_resp_data_i;
  logic        free_resp_val_i;
  logic        free_resp_rdy_o;
  logic [71:0] free_resp_data_i;
  logic        resp_val_o;
  logic        resp_rdy_i;
  logic [63:0] resp_data_o;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  falafel_output_serializer dut (
    .clk_i             (clk),
    .rst_i             (rst_i),
    .alloc_resp_val_i  (alloc_resp_val_i),
    .alloc_resp_rdy_o  (alloc_resp_rdy_o),
    .alloc_resp_data_i (alloc_resp_data_i),
    .free_resp_val_i   (free_resp_val_i),
    .free_resp_rdy_o   (free_resp_rdy_o),
    .free_resp_data_i  (free_resp_data_i),
    .resp_val_o        (resp_val_o),
    .resp_rdy_i        (resp_rdy_i),
    .resp_data_o       (resp_data_o),
    .busy_o            (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] hdr(input logic [7:0] op,
                                      input logic [7:0] id);
    return {48'h0, op, id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    alloc_resp_val_i = 1'b0;
    free_resp_val_i  = 1'b0;
    resp_rdy_i       = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    alloc_resp_val_i  = 1'b0;
    free_resp_val_i   = 1'b0;
    alloc_resp_data_i = '0;
    free_resp_data_i  = '0;
    resp_rdy_i        = 1'b0;
    step();
    step();
    rst_i = 1'b0;
    probe();
    n_tests += 5;
    if (resp_val_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_val got %b exp 0", resp_val_o);
    end
    if (resp_data_o !== 64'h0) begin
      n_fail++; $display("FAIL reset_data got %h exp 0", resp_data_o);
    end
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b exp 0", busy_o);
    end
    if (alloc_resp_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_alloc_rdy got %b exp 1", alloc_resp_rdy_o);
    end
    if (free_resp_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL reset_free_rdy got %b exp 1", free_resp_rdy_o);
    end
  endtask

  task automatic test_single();
    logic [64:0] exp [5];
    exp[0] = 65'h0;
    exp[1] = 65'h0;
    exp[2] = {1'b1, hdr(8'h01, 8'd3)};
    exp[3] = {1'b1, 64'h1000};
    exp[4] = 65'h0;
    step();
    alloc_resp_val_i  = 1'b1;
    alloc_resp_data_i = {8'd3, 64'h1000};
    resp_rdy_i        = 1'b1;
    probe();
    n_tests++;
    if (alloc_resp_rdy_o !== 1'b1) begin
      n_fail++; $display("FAIL single_rdy got %b exp 1", alloc_resp_rdy_o);
    end
    for (int c = 1; c < 5; c++) begin
      step();
      alloc_resp_val_i = 1'b0;
      probe();
      n_tests++;
      if ({resp_val_o, resp_data_o} !== exp[c]) begin
        n_fail++;
        $display("FAIL single_c%0d got %h exp %h", c,
                 {resp_val_o, resp_data_o}, exp[c]);
      end
    end
    n_tests++;
    if (busy_o !== 1'b0) begin
      n_fail++; $display("FAIL single_busy got %b exp 0", busy_o);
    end
  endtask

  task automatic test_arbitration();
    logic [64:0] exp [3][8];
    exp[0] = '{65'h0, 65'h0, {1'b1, hdr(8'h01, 8'd1)}, {1'b1, 64'hA1},
               65'h0, {1'b1, hdr(8'h02, 8'd2)}, {1'b1, 64'hF2}, 65'h0};
    exp[1] = '{65'h0, 65'h0, {1'b1, hdr(8'h01, 8'd5)}, {1'b1, 64'hA5},
               65'h0, 65'h0, 65'h0, 65'h0};
    exp[2] = '{65'h0, 65'h0, {1'b1, hdr(8'h02, 8'd7)}, {1'b1, 64'hF7},
               65'h0, {1'b1, hdr(8'h01, 8'd6)}, {1'b1, 64'hA6}, 65'h0};
    do_reset();
    for (int ph = 0; ph < 3; ph++) begin
      step();
      resp_rdy_i = 1'b1;
      alloc_resp_val_i = 1'b1;
      free_resp_val_i  = (ph != 1);
      alloc_resp_data_i = (ph == 0) ? {8'd1, 64'hA1} :
                          (ph == 1) ? {8'd5, 64'hA5} : {8'd6, 64'hA6};
      free_resp_data_i  = (ph == 0) ? {8'd2, 64'hF2} : {8'd7, 64'hF7};
      probe();
      for (int c = 0; c < 8; c++) begin
        if (c > 0) begin
          step();
          alloc_resp_val_i = 1'b0;
          free_resp_val_i  = 1'b0;
          probe();
        end
        n_tests++;
        if ({resp_val_o, resp_data_o} !== exp[ph][c]) begin
          n_fail++;
          $display("FAIL arb_p%0d_c%0d got %h exp %h", ph, c,
                   {resp_val_o, resp_data_o}, exp[ph][c]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [64:0] exp [13];
    exp[0] = 65'h0;
    exp[1] = 65'h0;
    for (int c = 2; c <= 7; c++) exp[c] = {1'b1, hdr(8'h01, 8'd9)};
    exp[8]  = {1'b1, 64'hBEEF};
    exp[9]  = 65'h0;
    exp[10] = {1'b1, hdr(8'h02, 8'd10)};
    exp[11] = {1'b1, 64'hF10};
    exp[12] = 65'h0;
    step();
    alloc_resp_val_i  = 1'b1;
    alloc_resp_data_i = {8'd9, 64'hBEEF};
    free_resp_data_i  = {8'd10, 64'hF10};
    resp_rdy_i        = 1'b0;
    probe();
    for (int c = 0; c < 13; c++) begin
      if (c > 0) begin
        step();
        alloc_resp_val_i = 1'b0;
        free_resp_val_i  = (c == 3);
        resp_rdy_i       = (c >= 7);
        probe();
      end
      n_tests++;
      if ({resp_val_o, resp_data_o} !== exp[c]) begin
        n_fail++;
        $display("FAIL bp_c%0d got %h exp %h", c,
                 {resp_val_o, resp_data_o}, exp[c]);
      end
    end
  endtask

  task automatic test_fifo_full();
    logic [63:0] got [$];
    logic [63:0] exp [6];
    int idx = 0;
    exp = '{hdr(8'h01, 8'd11), 64'h11, hdr(8'h01, 8'd12), 64'h12,
            hdr(8'h01, 8'd13), 64'h13};
    for (int cyc = 0; cyc < 60; cyc++) begin
      step();
      resp_rdy_i        = (cyc >= 3);
      alloc_resp_val_i  = (idx < 3);
      alloc_resp_data_i = {8'(11 + idx), 64'(17 + idx)};
      probe();
      if (cyc == 2 || cyc == 4) begin
        n_tests++;
        if (alloc_resp_rdy_o !== 1'b0) begin
          n_fail++;
          $display("FAIL full_rdy_c%0d got %b exp 0", cyc, alloc_resp_rdy_o);
        end
      end
      if (resp_val_o && resp_rdy_i) got.push_back(resp_data_o);
      if (alloc_resp_val_i && alloc_resp_rdy_o) idx++;
      if (idx == 3 && got.size() == 6) break;
    end
    alloc_resp_val_i = 1'b0;
    n_tests++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL full_count got %0d exp 6", got.size());
    end
    for (int i = 0; i < 6 && i < got.size(); i++) begin
      n_tests++;
      if (got[i] !== exp[i]) begin
        n_fail++;
        $display("FAIL full_w%0d got %h exp %h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    step();
    alloc_resp_val_i  = 1'b1;
    alloc_resp_data_i = {8'd20, 64'h2020};
    resp_rdy_i        = 1'b1;
    probe();
    step();
    alloc_resp_val_i = 1'b0;
    free_resp_val_i  = 1'b1;
    free_resp_data_i = {8'd21, 64'h2121};
    probe();
    step();
    free_resp_val_i = 1'b0;
    probe();
    n_tests++;
    if ({resp_val_o, resp_data_o} !== {1'b1, hdr(8'h01, 8'd20)}) begin
      n_fail++;
      $display("FAIL rmid_hdr got %h", {resp_val_o, resp_data_o});
    end
    step();
    resp_rdy_i = 1'b0;
    rst_i      = 1'b1;
    probe();
    n_tests++;
    if ({resp_val_o, resp_data_o} !== {1'b1, 64'h2020}) begin
      n_fail++;
      $display("FAIL rmid_data got %h exp %h",
               {resp_val_o, resp_data_o}, {1'b1, 64'h2020});
    end
    step();
    rst_i      = 1'b0;
    resp_rdy_i = 1'b1;
    probe();
    n_tests++;
    if ({resp_val_o, resp_data_o, busy_o} !== 66'h0) begin
      n_fail++;
      $display("FAIL rmid_after got val %b data %h busy %b exp 0",
               resp_val_o, resp_data_o, busy_o);
    end
    n_tests++;
    if ({alloc_resp_rdy_o, free_resp_rdy_o} !== 2'b11) begin
      n_fail++;
      $display("FAIL rmid_rdy got %b%b exp 11",
               alloc_resp_rdy_o, free_resp_rdy_o);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      probe();
      n_tests++;
      if (resp_val_o !== 1'b0) begin
        n_fail++; $display("FAIL rmid_quiet_c%0d got %b exp 0", c, resp_val_o);
      end
    end
  endtask

  task automatic test_random();
    logic [71:0] qa [$];
    logic [71:0] qf [$];
    logic [71:0] ent;
    logic [63:0] expw;
    logic [64:0] held_w;
    logic        held = 1'b0;
    logic        in_data = 1'b0;
    logic        ch_free = 1'b0;
    int pushed = 0;
    int deliv  = 0;
    int cyc    = 0;
    while (cyc < 20000 &&
           (pushed < 1000 || qa.size() > 0 || qf.size() > 0)) begin
      cyc++;
      step();
      alloc_resp_val_i  = (pushed < 1000) && ($urandom_range(0, 1) == 1);
      free_resp_val_i   = (pushed < 999) && ($urandom_range(0, 1) == 1);
      alloc_resp_data_i = {8'($urandom), $urandom, $urandom};
      free_resp_data_i  = {8'($urandom), $urandom, $urandom};
      resp_rdy_i        = ($urandom_range(0, 3) != 0);
      probe();
      if (held) begin
        n_tests++;
        if ({resp_val_o, resp_data_o} !== held_w) begin
          n_fail++;
          $display("FAIL rnd_hold got %h exp %h",
                   {resp_val_o, resp_data_o}, held_w);
        end
      end
      held   = resp_val_o && !resp_rdy_i;
      held_w = {resp_val_o, resp_data_o};
      if (resp_val_o && resp_rdy_i) begin
        n_tests++;
        if (!in_data) begin
          ch_free = (resp_data_o[15:8] == 8'h02);
          if (resp_data_o[63:16] !== 48'h0 ||
              (resp_data_o[15:8] != 8'h01 && resp_data_o[15:8] != 8'h02) ||
              (ch_free ? qf.size() : qa.size()) == 0) begin
            n_fail++;
            $display("FAIL rnd_hdr got %h unexpected", resp_data_o);
          end else begin
            ent  = ch_free ? qf[0] : qa[0];
            expw = hdr(resp_data_o[15:8], ent[71:64]);
            if (resp_data_o !== expw) begin
              n_fail++;
              $display("FAIL rnd_hdr got %h exp %h", resp_data_o, expw);
            end
            in_data = 1'b1;
          end
        end else begin
          ent = ch_free ? qf.pop_front() : qa.pop_front();
          if (resp_data_o !== ent[63:0]) begin
            n_fail++;
            $display("FAIL rnd_data got %h exp %h", resp_data_o, ent[63:0]);
          end
          deliv++;
          in_data = 1'b0;
        end
      end
      if (alloc_resp_val_i && alloc_resp_rdy_o) begin
        qa.push_back(alloc_resp_data_i); pushed++;
      end
      if (free_resp_val_i && free_resp_rdy_o) begin
        qf.push_back(free_resp_data_i); pushed++;
      end
    end
    alloc_resp_val_i = 1'b0;
    free_resp_val_i  = 1'b0;
    n_tests++;
    if (deliv != pushed || pushed != 1000 || in_data) begin
      n_fail++;
      $display("FAIL rnd_total got %0d delivered of %0d pushed exp 1000",
               deliv, pushed);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_backpressure();
    test_fifo_full();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
